// File: rtl/char_fifo_feeder_pkg.sv
// Shared constants for the char FIFO feeder and its id_fsm consumer:
// character width, character type and the default fill character.
package char_fifo_feeder_pkg;

  localparam int CHAR_W = 8;

  typedef logic [CHAR_W-1:0] char_t;

  // Character presented downstream on any cycle where nothing is popped
  localparam char_t FILL_CHAR_DEFAULT = 8'h00;

endpackage : char_fifo_feeder_pkg

// File: rtl/char_fifo_mem.sv
// Character storage for the feeder FIFO: DEPTH x CHAR_W, one synchronous
// write port and one asynchronous read port. Contents are never cleared;
// validity is tracked entirely by the pointers in the parent.
module char_fifo_mem
  import char_fifo_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [AW-1:0]     wrAddr_i,
  input  logic [CHAR_W-1:0] wrData_i,
  input  logic [AW-1:0]     rdAddr_i,
  output logic [CHAR_W-1:0] rdData_o
);

  char_t memArray [DEPTH];

  // Store the producer's char at the write address when a push is accepted
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      memArray[wrAddr_i] <= wrData_i;
    end
  end

  // The head entry is always visible so the parent can register it on a pop
  assign rdData_o = memArray[rdAddr_i];

endmodule : char_fifo_mem

// File: rtl/char_fifo_feeder.sv
// Character FIFO that feeds the id_fsm one registered char per cycle.
// The producer pushes through a valid/ready handshake; the consumer's adv
// strobe permits one pop per cycle. Cycles without a pop present FILL_CHAR
// with char_valid low. Pointers carry an extra MSB so that their difference
// distinguishes full from empty.
module char_fifo_feeder
  import char_fifo_feeder_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter logic [CHAR_W-1:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHAR_W-1:0]        in_char,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     adv,
  input  logic                     flush,
  output logic [CHAR_W-1:0]        char,
  output logic                     char_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [AW:0]       wrPtr_q, wrPtr_d;
  logic [AW:0]       rdPtr_q, rdPtr_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              charValid_q, charValid_d;
  logic              overflow_q, overflow_d;

  logic [AW:0]       occupancy;
  logic              isFull;
  logic              isEmpty;
  logic              doPush;
  logic              doPop;
  logic [CHAR_W-1:0] headChar;

  // Occupancy and handshake terms come only from registered pointers, so a
  // pop in the same cycle can never open in_ready on a full FIFO
  assign occupancy = wrPtr_q - rdPtr_q;
  assign isFull    = (occupancy == FULL_LEVEL);
  assign isEmpty   = (occupancy == '0);
  assign doPush    = in_valid && !isFull && !flush;
  assign doPop     = adv && !isEmpty && !flush;

  char_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .wrEn_i   (doPush),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wrData_i (in_char),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdData_o (headChar)
  );

  // Next-state: flush wins over everything, otherwise push/pop independently
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    char_d      = FILL_CHAR;
    charValid_d = 1'b0;
    overflow_d  = overflow_q;
    if (flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_d     = rdPtr_q + PTR_ONE;
        char_d      = headChar;
        charValid_d = 1'b1;
      end
      if (in_valid && isFull) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously so outputs react without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      char_q      <= FILL_CHAR;
      charValid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      char_q      <= char_d;
      charValid_q <= charValid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready   = !isFull;
  assign char       = char_q;
  assign char_valid = charValid_q;
  assign level      = occupancy;
  assign overflow   = overflow_q;

endmodule : char_fifo_feeder

// File: tb/tb_char_fifo_feeder.sv
// Directed testbench for char_fifo_feeder (DEPTH=8, FILL_CHAR=8'h00).
module tb_char_fifo_feeder;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic       adv;
  logic       flush;
  logic [7:0] char;
  logic       char_valid;
  logic [3:0] level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  char_fifo_feeder #(
    .DEPTH     (8),
    .FILL_CHAR (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_char    (in_char),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .adv        (adv),
    .flush      (flush),
    .char       (char),
    .char_valid (char_valid),
    .level      (level),
    .overflow   (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, then advance past the next rising edge
  task automatic applyStimulus(input logic v, input logic [7:0] c,
                               input logic a, input logic f);
    in_valid = v;
    in_char  = c;
    adv      = a;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and counts/reports it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] seqChars [4];
    seqChars[0] = "a";
    seqChars[1] = "b";
    seqChars[2] = "1";
    seqChars[3] = "2";

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    adv      = 1'b0;
    flush    = 1'b0;

    // Reset state, observed before any clock edge
    #3;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_char", char, 8'h00);
    checkOutput("rst_cvalid", char_valid, 0);
    checkOutput("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // "a","b","1","2" with adv held high: each emerges one edge after its write
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seqChars[i], 1'b1, 1'b0);
      if (i == 0) begin
        checkOutput("stream_first_char", char, 8'h00);
        checkOutput("stream_first_cvalid", char_valid, 0);
      end else begin
        checkOutput("stream_char", char, seqChars[i-1]);
        checkOutput("stream_cvalid", char_valid, 1);
      end
      checkOutput("stream_level", level, 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_last_char", char, "2");
    checkOutput("stream_last_cvalid", char_valid, 1);
    checkOutput("stream_last_level", level, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_fill_char", char, 8'h00);
    checkOutput("stream_fill_cvalid", char_valid, 0);

    // Fill to 8 with adv low, offer a 9th, then drain in order
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      checkOutput("fill_level", level, i + 1);
      checkOutput("fill_cvalid", char_valid, 0);
    end
    checkOutput("full_ready", in_ready, 0);
    checkOutput("full_ovf_before", overflow, 0);
    applyStimulus(1'b1, 8'h58, 1'b0, 1'b0);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_level", level, 8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_char", char, 8'h30 + i);
      checkOutput("drain_cvalid", char_valid, 1);
      checkOutput("drain_level", level, 7 - i);
    end
    checkOutput("drain_ovf_sticky", overflow, 1);
    checkOutput("drain_ready", in_ready, 1);

    // Full FIFO with write and pop together: pop only, then next write accepted
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    end
    checkOutput("full2_level", level, 8);
    checkOutput("full2_ready", in_ready, 0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("fullpop_char", char, 8'h40);
    checkOutput("fullpop_level", level, 7);
    checkOutput("fullpop_ready", in_ready, 1);
    applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
    checkOutput("fullpop_next_level", level, 8);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("fullpop_drain_char", char, 8'h40 + i);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fullpop_tail_char", char, 8'h56);
    checkOutput("fullpop_tail_level", level, 0);

    // Level 3 with simultaneous push and pop: level holds, order kept
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h64, 1'b1, 1'b0);
    checkOutput("pushpop_char", char, 8'h61);
    checkOutput("pushpop_level", level, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pushpop_order", char, 8'h62 + i);
      checkOutput("pushpop_cvalid", char_valid, 1);
    end
    checkOutput("pushpop_empty", level, 0);

    // Flush beats a simultaneous write and pop
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    end
    checkOutput("preflush_level", level, 5);
    checkOutput("preflush_ovf", overflow, 1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
    checkOutput("flush_level", level, 0);
    checkOutput("flush_ovf", overflow, 0);
    checkOutput("flush_char", char, 8'h00);
    checkOutput("flush_cvalid", char_valid, 0);
    checkOutput("flush_ready", in_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("postflush_char", char, 8'h00);
    checkOutput("postflush_cvalid", char_valid, 0);
    checkOutput("postflush_level", level, 0);

    // Asynchronous reset mid-cycle at level 4 with a valid char on the output
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h84, 1'b1, 1'b0);
    checkOutput("prerst_level", level, 4);
    checkOutput("prerst_char", char, 8'h80);
    checkOutput("prerst_cvalid", char_valid, 1);
    in_valid = 1'b0;
    adv      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_level", level, 0);
    checkOutput("arst_char", char, 8'h00);
    checkOutput("arst_cvalid", char_valid, 0);
    checkOutput("arst_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("postrst_char", char, 8'h00);
      checkOutput("postrst_cvalid", char_valid, 0);
      checkOutput("postrst_level", level, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_char_fifo_feeder

// File: doc/char_fifo_feeder.md
CHAR_FIFO_FEEDER -- requirements
Module: char_fifo_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter FILL_CHAR, default 8'h00, the char driven when no entry is popped.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_char  input  8  write data from the producer.
REQ-006 SHALL have port in_valid  input  1  producer offers in_char this cycle.
REQ-007 SHALL have port in_ready  output  1  FIFO accepts a write this cycle (not full).
REQ-008 SHALL have port adv  input  1  advance strobe; permits one pop this cycle.
REQ-009 SHALL have port flush  input  1  synchronous clear of FIFO contents and flags.
REQ-010 SHALL have port char  output  8  registered char presented to the downstream id_fsm every cycle.
REQ-011 SHALL have port char_valid  output  1  registered; char came from the FIFO, not fill.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky; a write was offered while full.

Function
REQ-014 SHALL accept a write when in_valid && in_ready; in_ready SHALL equal (level != DEPTH) combinationally from registered state.
REQ-015 SHALL pop the head entry when adv && (level != 0), loading it into char with char_valid=1 at that edge.
REQ-016 SHALL load char=FILL_CHAR and char_valid=0 on every edge with no pop, including adv=1 while empty.
REQ-017 SHALL give latency of 1 edge from an accepted write to char when the FIFO is empty and adv=1 on the following cycle; no write-through in the same cycle.
REQ-018 SHALL perform push and pop in the same cycle when both are permitted; level unchanged; order preserved.
REQ-019 SHALL, when full, keep in_ready=0 even if a pop occurs that cycle; the write is not accepted.
REQ-020 SHALL set overflow on any edge where in_valid=1 and level==DEPTH; it SHALL hold until flush or reset.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; level SHALL track write-minus-read with an extra MSB to distinguish full from empty.
REQ-022 SHALL give flush priority over push and pop in the same cycle: level=0, pointers=0, overflow=0, char=FILL_CHAR, char_valid=0; the write offered that cycle is discarded.
REQ-023 SHALL preserve strict FIFO order; no entry popped twice or skipped.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force level=0, pointers=0, overflow=0, char=FILL_CHAR, char_valid=0; in_ready SHALL read 1.
REQ-025 SHALL discard all FIFO contents on reset mid-operation; storage array contents need not be cleared.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place FILL_CHAR default and char width (8) in a shared package; the id_fsm consumer uses the same constants.
REQ-028 SHALL be split into a storage sub-module char_fifo_mem (DEPTH x 8, one write and one read port), with pointer, level and flag logic in char_fifo_feeder.
REQ-029 SHALL place no logic between the char register and the char port.

Verification
REQ-030 SHALL verify this sequence: reset, then write "a","b","1","2" on consecutive cycles with adv=1 throughout -> char reads "a","b","1","2" on consecutive edges, each one edge after its write, char_valid=1, then 8'h00 with char_valid=0.
REQ-031 SHALL verify this sequence: adv=0, write 8 chars -> level=8, in_ready=0; a 9th offer -> overflow=1 and level stays 8; then adv=1 for 8 cycles -> the 8 chars come out in order and level reaches 0.
REQ-032 SHALL verify this sequence: full FIFO, in_valid=1 and adv=1 for one cycle -> one pop, no push, level=7; the next cycle's write is accepted.
REQ-033 SHALL verify this sequence: level=3 and adv=1 with push in the same cycle -> level stays 3 and the pushed char emerges after the 3 older ones.
REQ-034 SHALL verify this sequence: level=5 and overflow=1, flush with in_valid=1 and adv=1 -> next edge level=0, overflow=0, char=8'h00, char_valid=0.
REQ-035 SHALL verify this sequence: rst_n pulsed low between edges with level=4 -> outputs reset immediately without a clock edge; after release, adv=1 yields only fill chars.
